// File: rtl/vending_pkg.sv
// Shared vending machine types: coin encodings, coin values and FSM states.
// Used by both the vending controller and the change dispenser.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_2RS  = 2'b01;
    localparam logic [1:0] COIN_5RS  = 2'b10;
    localparam logic [1:0] COIN_10RS = 2'b11;

    localparam logic [7:0] VAL_2RS  = 8'd2;
    localparam logic [7:0] VAL_5RS  = 8'd5;
    localparam logic [7:0] VAL_10RS = 8'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_DONE
    } state_t;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        logic [7:0] v;
        case (code)
            COIN_2RS:  v = VAL_2RS;
            COIN_5RS:  v = VAL_5RS;
            COIN_10RS: v = VAL_10RS;
            default:   v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Largest-first coin choice; rejects coins leaving 1 or 3 rupees,
// since those remainders can never be paid with 2/5/10 coins.
module coin_selector
    import vending_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [7:0]       remaining,
    input  logic [CNT_W-1:0] cnt_2,
    input  logic [CNT_W-1:0] cnt_5,
    input  logic [CNT_W-1:0] cnt_10,
    output logic             found,
    output logic [1:0]       coin
);

    function automatic logic fits(input logic [7:0] rem,
                                  input logic [7:0] val,
                                  input logic       avail);
        logic [7:0] left;
        left = rem - val;
        return avail && (val <= rem) && (left != 8'd1) && (left != 8'd3);
    endfunction

    logic fit_2;
    logic fit_5;
    logic fit_10;

    assign fit_2  = fits(remaining, VAL_2RS,  |cnt_2);
    assign fit_5  = fits(remaining, VAL_5RS,  |cnt_5);
    assign fit_10 = fits(remaining, VAL_10RS, |cnt_10);

    always_comb begin
        found = 1'b1;
        coin  = COIN_NONE;
        if (fit_10) begin
            coin = COIN_10RS;
        end else if (fit_5) begin
            coin = COIN_5RS;
        end else if (fit_2) begin
            coin = COIN_2RS;
        end else begin
            found = 1'b0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin at a time over a valid/ack hopper handshake,
// keeping saturating per-denomination inventory and a sticky jam flag.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int INIT_CNT_2  = 20,
    parameter int INIT_CNT_5  = 20,
    parameter int INIT_CNT_10 = 20,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [7:0]       change_amount,
    output logic             change_ready,
    output logic             eject_valid,
    output logic [1:0]       eject_coin,
    input  logic             eject_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    input  logic [CNT_W-1:0] refill_qty,
    output logic             done,
    output logic [7:0]       shortfall,
    output logic             error,
    output logic             jam,
    output logic [CNT_W-1:0] cnt_2,
    output logic [CNT_W-1:0] cnt_5,
    output logic [CNT_W-1:0] cnt_10
);

    localparam int               TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nx;
    logic [7:0]       remaining;
    logic [1:0]       coin_q;
    logic [TW-1:0]    tmo;
    logic             sel_found;
    logic [1:0]       sel_coin;
    logic             accept;
    logic             ack_take;
    logic             timeout;

    coin_selector #(
        .CNT_W (CNT_W)
    ) u_sel (
        .remaining (remaining),
        .cnt_2     (cnt_2),
        .cnt_5     (cnt_5),
        .cnt_10    (cnt_10),
        .found     (sel_found),
        .coin      (sel_coin)
    );

    assign accept   = change_valid && change_ready;
    assign ack_take = (state == ST_EJECT) && eject_ack;
    assign timeout  = (state == ST_EJECT) && !eject_ack && (tmo == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        change_ready = 1'b0;
        eject_valid  = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                change_ready = !jam;
                if (accept) state_nx = ST_SELECT;
            end
            ST_SELECT: begin
                state_nx = sel_found ? ST_EJECT : ST_DONE;
            end
            ST_EJECT: begin
                eject_valid = 1'b1;
                if (eject_ack) begin
                    state_nx = ST_SELECT;
                end else if (timeout) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                error    = (shortfall != 8'd0) || jam;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign eject_coin = coin_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= 8'd0;
            shortfall <= 8'd0;
            coin_q    <= COIN_NONE;
            tmo       <= '0;
            jam       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        remaining <= change_amount;
                        shortfall <= 8'd0;
                    end
                end
                ST_SELECT: begin
                    if (sel_found) begin
                        coin_q <= sel_coin;
                        tmo    <= '0;
                    end else begin
                        shortfall <= remaining;
                    end
                end
                ST_EJECT: begin
                    if (eject_ack) begin
                        remaining <= remaining - coin_value(coin_q);
                        coin_q    <= COIN_NONE;
                    end else if (timeout) begin
                        jam       <= 1'b1;
                        shortfall <= remaining;
                        coin_q    <= COIN_NONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Refill and eject on the same counter net out before saturation.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic [1:0]       code);
        logic [CNT_W:0] s;
        logic [CNT_W:0] add;
        logic [CNT_W:0] dec;
        add = (refill_valid && refill_coin == code) ? {1'b0, refill_qty} : '0;
        dec = (ack_take && coin_q == code) ? (CNT_W+1)'(1) : '0;
        s   = {1'b0, cnt} + add - dec;
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_2  <= CNT_W'(INIT_CNT_2);
            cnt_5  <= CNT_W'(INIT_CNT_5);
            cnt_10 <= CNT_W'(INIT_CNT_10);
        end else begin
            cnt_2  <= cnt_next(cnt_2,  COIN_2RS);
            cnt_5  <= cnt_next(cnt_5,  COIN_5RS);
            cnt_10 <= cnt_next(cnt_10, COIN_10RS);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin order, feasibility,
// shortfall, refill saturation, jam timeout and async reset.
module tb_change_dispenser;
    import vending_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = 8'd0;
    logic       change_ready;
    logic       eject_valid;
    logic [1:0] eject_coin;
    logic       eject_ack = 1'b0;
    logic       refill_valid = 1'b0;
    logic [1:0] refill_coin = 2'b00;
    logic [7:0] refill_qty = 8'd0;
    logic       done;
    logic [7:0] shortfall;
    logic       error;
    logic       jam;
    logic [7:0] cnt_2;
    logic [7:0] cnt_5;
    logic [7:0] cnt_10;

    change_dispenser #(
        .CNT_W       (8),
        .INIT_CNT_2  (20),
        .INIT_CNT_5  (20),
        .INIT_CNT_10 (20),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .change_ready  (change_ready),
        .eject_valid   (eject_valid),
        .eject_coin    (eject_coin),
        .eject_ack     (eject_ack),
        .refill_valid  (refill_valid),
        .refill_coin   (refill_coin),
        .refill_qty    (refill_qty),
        .done          (done),
        .shortfall     (shortfall),
        .error         (error),
        .jam           (jam),
        .cnt_2         (cnt_2),
        .cnt_5         (cnt_5),
        .cnt_10        (cnt_10)
    );

    always #5 clk = ~clk;

    int         npass = 0;
    int         nfail = 0;
    int         ntot  = 0;
    logic [1:0] coins[$];
    int         ev_cyc;
    logic       got_done;
    logic [7:0] got_short;
    logic       got_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int n_code(input logic [1:0] c);
        int n = 0;
        foreach (coins[i]) if (coins[i] == c) n++;
        return n;
    endfunction

    task automatic do_req(input logic [7:0] amt, input bit ack_on);
        coins.delete();
        ev_cyc    = 0;
        got_done  = 1'b0;
        got_short = 8'hxx;
        got_err   = 1'bx;
        @(negedge clk);
        change_valid  = 1'b1;
        change_amount = amt;
        @(negedge clk);
        change_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got_done  = 1'b1;
                got_short = shortfall;
                got_err   = error;
                break;
            end
            if (eject_valid) begin
                ev_cyc++;
                if (ack_on) coins.push_back(eject_coin);
            end
            eject_ack = ack_on && eject_valid;
            @(negedge clk);
        end
        eject_ack = 1'b0;
        chk("req_done", 32'(got_done), 32'd1);
    endtask

    task automatic do_refill(input logic [1:0] code, input logic [7:0] qty);
        @(negedge clk);
        refill_valid = 1'b1;
        refill_coin  = code;
        refill_qty   = qty;
        @(negedge clk);
        refill_valid = 1'b0;
        refill_coin  = COIN_NONE;
        refill_qty   = 8'd0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(change_ready), 32'd1);
        chk("rst_ev", 32'(eject_valid), 32'd0);
        chk("rst_coin", 32'(eject_coin), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_jam", 32'(jam), 32'd0);
        chk("rst_short", 32'(shortfall), 32'd0);
        chk("rst_cnt2", 32'(cnt_2), 32'd20);
        chk("rst_cnt10", 32'(cnt_10), 32'd20);

        do_req(8'd17, 1'b1);
        chk("a17_n", coins.size(), 32'd3);
        chk("a17_c0", 32'(coins[0]), 32'(COIN_10RS));
        chk("a17_c1", 32'(coins[1]), 32'(COIN_5RS));
        chk("a17_c2", 32'(coins[2]), 32'(COIN_2RS));
        chk("a17_short", 32'(got_short), 32'd0);
        chk("a17_err", 32'(got_err), 32'd0);
        chk("a17_cnt", {8'd0, cnt_10, cnt_5, cnt_2}, {8'd0, 8'd19, 8'd19, 8'd19});

        do_req(8'd8, 1'b1);
        chk("a8_n", coins.size(), 32'd4);
        chk("a8_twos", n_code(COIN_2RS), 32'd4);
        chk("a8_short", 32'(got_short), 32'd0);
        chk("a8_cnt", {8'd0, cnt_10, cnt_5, cnt_2}, {8'd0, 8'd19, 8'd19, 8'd15});

        do_req(8'd0, 1'b1);
        chk("a0_n", coins.size(), 32'd0);
        chk("a0_err", 32'(got_err), 32'd0);
        chk("a0_short", 32'(got_short), 32'd0);

        do_req(8'd190, 1'b1);
        chk("a190_tens", n_code(COIN_10RS), 32'd19);
        chk("a190_cnt10", 32'(cnt_10), 32'd0);
        do_req(8'd90, 1'b1);
        chk("a90_fives", n_code(COIN_5RS), 32'd18);
        chk("a90_cnt5", 32'(cnt_5), 32'd1);
        do_req(8'd8, 1'b1);
        do_req(8'd8, 1'b1);
        do_req(8'd8, 1'b1);
        do_req(8'd4, 1'b1);
        chk("dep_cnt2", 32'(cnt_2), 32'd1);

        do_req(8'd13, 1'b1);
        chk("a13_n", coins.size(), 32'd2);
        chk("a13_c0", 32'(coins[0]), 32'(COIN_5RS));
        chk("a13_c1", 32'(coins[1]), 32'(COIN_2RS));
        chk("a13_short", 32'(got_short), 32'd6);
        chk("a13_err", 32'(got_err), 32'd1);
        chk("a13_cnt", {8'd0, cnt_10, cnt_5, cnt_2}, 32'd0);

        do_refill(COIN_2RS, 8'd5);
        chk("refill5", 32'(cnt_2), 32'd5);

        @(negedge clk);
        change_valid  = 1'b1;
        change_amount = 8'd2;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        chk("ra_ev", 32'(eject_valid), 32'd1);
        chk("ra_coin", 32'(eject_coin), 32'(COIN_2RS));
        eject_ack    = 1'b1;
        refill_valid = 1'b1;
        refill_coin  = COIN_2RS;
        refill_qty   = 8'd10;
        @(negedge clk);
        eject_ack    = 1'b0;
        refill_valid = 1'b0;
        chk("ra_cnt2", 32'(cnt_2), 32'd14);
        @(negedge clk);
        chk("ra_done", 32'(done), 32'd1);
        chk("ra_err", 32'(error), 32'd0);

        do_refill(COIN_NONE, 8'd7);
        chk("ref00", {8'd0, cnt_10, cnt_5, cnt_2}, {8'd0, 8'd0, 8'd0, 8'd14});
        do_refill(COIN_2RS, 8'd250);
        chk("sat", 32'(cnt_2), 32'd255);
        do_refill(COIN_10RS, 8'd2);
        chk("ref10", 32'(cnt_10), 32'd2);

        do_req(8'd10, 1'b0);
        chk("jam_evcyc", ev_cyc, 32'd4);
        chk("jam_short", 32'(got_short), 32'd10);
        chk("jam_err", 32'(got_err), 32'd1);
        chk("jam_flag", 32'(jam), 32'd1);
        chk("jam_cnt10", 32'(cnt_10), 32'd2);
        @(negedge clk);
        chk("jam_ready", 32'(change_ready), 32'd0);
        change_valid  = 1'b1;
        change_amount = 8'd4;
        repeat (3) @(negedge clk);
        chk("jam_noev", 32'(eject_valid), 32'd0);
        chk("jam_nocnt", 32'(cnt_2), 32'd255);
        change_valid = 1'b0;

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rr_jam", 32'(jam), 32'd0);
        @(negedge clk);
        change_valid  = 1'b1;
        change_amount = 8'd10;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_ev", 32'(eject_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_ev0", 32'(eject_valid), 32'd0);
        chk("mid_coin", 32'(eject_coin), 32'd0);
        chk("mid_ready", 32'(change_ready), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_cnt", {8'd0, cnt_10, cnt_5, cnt_2}, {8'd0, 8'd20, 8'd20, 8'd20});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
